// File: rtl/hankel_stream_gen.sv
// rtl/hankel_stream_gen.sv - loads 2N-1 samples from memory and streams the NxN Hankel matrix
//
// Purpose:
//   On an accepted start, reads x[0..2N-2] from a synchronous sample memory
//   (one-cycle read latency) into a local buffer.
//   It then emits H[i][j] = x[i+j] row-major on a valid/ready stream, one beat per
//   accepted handshake.
//
// Build option:
//   HANKEL_TOEPLITZ_EN adds the toep input, which is sampled with start.
//   With toep=1 the block emits T[i][j] = x[N-1+i-j] instead.
//   The load sequence, timing, indices and handshake are unchanged.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, base           job request pulse and x[0] address (sampled in IDLE)
//   toep                  Toeplitz select (only with HANKEL_TOEPLITZ_EN)
//   addr, rd, data        sample memory read port (data valid the cycle after rd)
//   out_data/row/col      current matrix element and its indices
//   out_last              marks element (N-1,N-1)
//   out_valid, out_ready  stream handshake
//   busy, done            job in progress, one-cycle completion pulse
module hankel_stream_gen #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int N  = 8,
  parameter int IW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
`ifdef HANKEL_TOEPLITZ_EN
  input  logic          toep,
`endif
  output logic [AW-1:0] addr,
  output logic          rd,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_row,
  output logic [IW-1:0] out_col,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int            L       = 2*N - 1;
  localparam logic [IW-1:0] LAST_K  = IW'(L - 1);
  localparam logic [IW-1:0] LAST_RC = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          rd_q, rd_d;
  logic [IW-1:0] k_q, k_d;
  logic          cap_v_q, cap_v_d;
  logic [IW-1:0] cap_idx_q, cap_idx_d;
  logic          toep_q, toep_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [IW-1:0] out_row_q, out_row_d;
  logic [IW-1:0] out_col_q, out_col_d;
  logic          out_last_q, out_last_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [IW-1:0] nxt_row, nxt_col;
  logic          toep_in;

  logic [DW-1:0] sbuf_q [L];

`ifdef HANKEL_TOEPLITZ_EN
  assign toep_in = toep;
`else
  assign toep_in = 1'b0;
`endif

  // Buffer index for element (r,c). Both results lie in 0..2N-2, so modular
  // IW-bit arithmetic yields the exact value.
  function automatic logic [IW-1:0] sel_idx(input logic [IW-1:0] r,
                                            input logic [IW-1:0] c,
                                            input logic          tp);
    if (tp) return LAST_RC + r - c;
    return r + c;
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    k_d         = k_q;
    cap_v_d     = cap_v_q;
    cap_idx_d   = cap_idx_q;
    toep_d      = toep_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    nxt_row     = out_row_q;
    nxt_col     = out_col_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          addr_d    = base;
          rd_d      = 1'b1;
          k_d       = '0;
          cap_v_d   = 1'b0;
          cap_idx_d = '0;
          toep_d    = toep_in;
          busy_d    = 1'b1;
        end
      end

      S_LOAD: begin
        // Capture strobe trails the read strobe by the memory latency.
        cap_v_d = rd_q;
        if (rd_q) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST_K) rd_d = 1'b0;
          else               addr_d = addr_q + 1'b1;
        end
        if (cap_v_q) begin
          cap_idx_d = cap_idx_q + 1'b1;
          if (cap_idx_q == LAST_K) begin
            // The first element (index 0 or N-1) was captured earlier.
            // That lets it be read from the buffer in the same cycle as the final capture.
            state_d     = S_EMIT;
            out_valid_d = 1'b1;
            out_row_d   = '0;
            out_col_d   = '0;
            out_last_d  = 1'b0;
            out_data_d  = sbuf_q[sel_idx('0, '0, toep_q)];
          end
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = S_DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            out_row_d   = '0;
            out_col_d   = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            if (out_col_q == LAST_RC) begin
              nxt_row = out_row_q + 1'b1;
              nxt_col = '0;
            end else begin
              nxt_col = out_col_q + 1'b1;
            end
            out_row_d  = nxt_row;
            out_col_d  = nxt_col;
            out_last_d = (nxt_row == LAST_RC) && (nxt_col == LAST_RC);
            out_data_d = sbuf_q[sel_idx(nxt_row, nxt_col, toep_q)];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      k_q         <= '0;
      cap_v_q     <= 1'b0;
      cap_idx_q   <= '0;
      toep_q      <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      k_q         <= k_d;
      cap_v_q     <= cap_v_d;
      cap_idx_q   <= cap_idx_d;
      toep_q      <= toep_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Sample storage has no reset; it is always fully rewritten before being read.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && cap_v_q) sbuf_q[cap_idx_q] <= data;
  end

  assign addr      = addr_q;
  assign rd        = rd_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
